phase_sequencer: RTL and testbench

- Intersection controller that sits on the consuming end of the per-approach green timers (timer1..timer4).
- Drives one level enable per approach timer and consumes each timer's expiry flag.
- Sequences green → yellow → all-red for four approaches.
- Skips approaches with no vehicle demand; ends a green early on a sensor gap when another approach is waiting.

---
 rtl/phase_sequencer.sv | 146 ++++++++++++++
 tb/tb_phase_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Four-approach intersection phase sequencer: green -> yellow -> all-red,
// skipping approaches without demand and gapping out idle greens.
module phase_sequencer #(
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned GAP_CYC    = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sensor,
  input  logic [3:0] timer_expired,
  output logic [3:0] timer_en,
  output logic [7:0] lights,
  output logic [1:0] phase,
  output logic [1:0] state_o
);

  localparam int unsigned N_APP = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    S_ALL_RED = 2'b00,
    S_GREEN   = 2'b01,
    S_YELLOW  = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [N_APP-1:0]   timer_en_q, timer_en_d;
  logic [2*N_APP-1:0] lights_q, lights_d;
  logic [IDX_W-1:0]   phase_q, phase_d;
  logic [1:0]         state_o_q, state_o_d;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   idx;
  logic [N_APP-1:0]   cur_oh;
  logic               gap_sat;
  logic               other_demand;

  // Round-robin search starting just after the current approach, ending on it.
  always_comb begin
    found = 1'b0;
    pick  = cur_q;
    idx   = cur_q;
    for (int k = 1; k <= N_APP; k++) begin
      idx = cur_q + IDX_W'(k);
      if (!found && sensor[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign cur_oh       = N_APP'(1) << cur_q;
  assign gap_sat      = (gap_q == CNT_W'(GAP_CYC));
  assign other_demand = |(sensor & ~cur_oh);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    timer_en_d = '0;
    lights_d   = '0;

    case (state_q)
      S_ALL_RED: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (found) begin
          state_d = S_GREEN;
          cur_d   = pick;
          gap_d   = '0;
        end
      end
      S_GREEN: begin
        if (sensor[cur_q]) begin
          gap_d = '0;
        end else if (!gap_sat) begin
          gap_d = gap_q + CNT_W'(1);
        end
        if (timer_expired[cur_q] || (gap_sat && other_demand)) begin
          state_d = S_YELLOW;
          cnt_d   = CNT_W'(YELLOW_CYC - 1);
        end
      end
      S_YELLOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_ALL_RED;
          cnt_d   = CNT_W'(ALLRED_CYC - 1);
        end
      end
      default: begin
        state_d = S_ALL_RED;
        cnt_d   = CNT_W'(ALLRED_CYC);
      end
    endcase

    // Output image is decoded from the next state so outputs are flops.
    case (state_d)
      S_GREEN: begin
        timer_en_d                  = N_APP'(1) << cur_d;
        lights_d[{cur_d, 1'b0} +: 2] = 2'b01;
      end
      S_YELLOW: lights_d[{cur_d, 1'b0} +: 2] = 2'b10;
      default:  lights_d = '0;
    endcase

    phase_d   = cur_d;
    state_o_d = state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_ALL_RED;
      cur_q      <= IDX_W'(N_APP - 1);
      cnt_q      <= CNT_W'(ALLRED_CYC);
      gap_q      <= '0;
      timer_en_q <= '0;
      lights_q   <= '0;
      phase_q    <= IDX_W'(N_APP - 1);
      state_o_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      timer_en_q <= timer_en_d;
      lights_q   <= lights_d;
      phase_q    <= phase_d;
      state_o_q  <= state_o_d;
    end
  end

  assign timer_en = timer_en_q;
  assign lights   = lights_q;
  assign phase    = phase_q;
  assign state_o  = state_o_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Vector-table bench for phase_sequencer with a queue-based scoreboard and
// per-cycle output invariant checks.
module tb_phase_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] sensor;
  logic [3:0] timer_expired;
  logic [3:0] timer_en;
  logic [7:0] lights;
  logic [1:0] phase;
  logic [1:0] state_o;

  phase_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .sensor        (sensor),
    .timer_expired (timer_expired),
    .timer_en      (timer_en),
    .lights        (lights),
    .phase         (phase),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] sen;
    logic [3:0] tex;
    logic [7:0] l;
    logic [3:0] te;
    logic [1:0] ph;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input int n, input logic r, input logic [3:0] s, input logic [3:0] t,
                     input logic [7:0] l, input logic [3:0] te, input logic [1:0] ph,
                     input logic [1:0] st);
    vec_t v;
    v.rst = r; v.sen = s; v.tex = t; v.l = l; v.te = te; v.ph = ph; v.st = st;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic check_invariants(input int id);
    int nonred;
    logic bad11;
    nonred = 0;
    bad11  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lights[2*i +: 2] != 2'b00) nonred++;
      if (lights[2*i +: 2] == 2'b11) bad11 = 1'b1;
    end
    n_vec++;
    if (nonred > 1 || bad11) begin
      n_err++;
      $display("FAIL inv_lights cyc %0d got lights=%h required one-or-none non-red, no 11", id, lights);
    end
    n_vec++;
    if (timer_en != 4'h0 && !(state_o == 2'b01 && timer_en == (4'b0001 << phase))) begin
      n_err++;
      $display("FAIL inv_timer_en cyc %0d got timer_en=%b state=%b phase=%0d", id, timer_en, state_o, phase);
    end
  endtask

  task automatic compare(input int id);
    vec_t e;
    e = exp_q.pop_front();
    n_vec++;
    if (lights !== e.l || timer_en !== e.te || phase !== e.ph || state_o !== e.st) begin
      n_err++;
      $display("FAIL vec %0d got lights=%h en=%b ph=%0d st=%b required lights=%h en=%b ph=%0d st=%b",
               id, lights, timer_en, phase, state_o, e.l, e.te, e.ph, e.st);
    end
    check_invariants(id);
  endtask

  task automatic drive(input logic r, input logic [3:0] s, input logic [3:0] t);
    @(negedge clk);
    reset         = r;
    sensor        = s;
    timer_expired = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    reset = 1'b0; sensor = 4'h0; timer_expired = 4'h0;

    // Reset then idle with no demand
    add(3, 0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 2'd3, 2'd0);
    add(5, 1, 4'b0000, 4'b0000, 8'h00, 4'b0000, 2'd3, 2'd0);
    // Single demand on approach 0, expiry, self-reselect
    add(1, 0, 4'b0001, 4'b0000, 8'h00, 4'b0000, 2'd3, 2'd0);
    add(2, 1, 4'b0001, 4'b0000, 8'h00, 4'b0000, 2'd3, 2'd0);
    add(2, 1, 4'b0001, 4'b0000, 8'h01, 4'b0001, 2'd0, 2'd1);
    add(1, 1, 4'b0001, 4'b0001, 8'h02, 4'b0000, 2'd0, 2'd2);
    add(2, 1, 4'b0001, 4'b0000, 8'h02, 4'b0000, 2'd0, 2'd2);
    add(2, 1, 4'b0001, 4'b0000, 8'h00, 4'b0000, 2'd0, 2'd0);
    add(1, 1, 4'b0001, 4'b0000, 8'h01, 4'b0001, 2'd0, 2'd1);
    add(1, 1, 4'b0001, 4'b0001, 8'h02, 4'b0000, 2'd0, 2'd2);
    // Skip order 1 -> 3 -> 1 under sensor 1010
    add(2, 1, 4'b1010, 4'b0000, 8'h02, 4'b0000, 2'd0, 2'd2);
    add(2, 1, 4'b1010, 4'b0000, 8'h00, 4'b0000, 2'd0, 2'd0);
    add(1, 1, 4'b1010, 4'b0000, 8'h04, 4'b0010, 2'd1, 2'd1);
    add(1, 1, 4'b1010, 4'b0010, 8'h08, 4'b0000, 2'd1, 2'd2);
    add(2, 1, 4'b1010, 4'b0000, 8'h08, 4'b0000, 2'd1, 2'd2);
    add(2, 1, 4'b1010, 4'b0000, 8'h00, 4'b0000, 2'd1, 2'd0);
    add(1, 1, 4'b1010, 4'b0000, 8'h40, 4'b1000, 2'd3, 2'd1);
    add(1, 1, 4'b1010, 4'b1000, 8'h80, 4'b0000, 2'd3, 2'd2);
    add(2, 1, 4'b1010, 4'b0000, 8'h80, 4'b0000, 2'd3, 2'd2);
    add(2, 1, 4'b1010, 4'b0000, 8'h00, 4'b0000, 2'd3, 2'd0);
    add(1, 1, 4'b1010, 4'b0000, 8'h04, 4'b0010, 2'd1, 2'd1);
    // Gap-out on approach 1 with demand on 2
    add(4, 1, 4'b0100, 4'b0000, 8'h04, 4'b0010, 2'd1, 2'd1);
    add(3, 1, 4'b0100, 4'b0000, 8'h08, 4'b0000, 2'd1, 2'd2);
    add(2, 1, 4'b0100, 4'b0000, 8'h00, 4'b0000, 2'd1, 2'd0);
    // No competing demand: green held past gap saturation; foreign expiries ignored
    add(1, 1, 4'b0010, 4'b0000, 8'h04, 4'b0010, 2'd1, 2'd1);
    add(3, 1, 4'b0000, 4'b0000, 8'h04, 4'b0010, 2'd1, 2'd1);
    add(1, 1, 4'b0000, 4'b0101, 8'h04, 4'b0010, 2'd1, 2'd1);
    add(2, 1, 4'b0000, 4'b0000, 8'h04, 4'b0010, 2'd1, 2'd1);
    add(1, 1, 4'b0000, 4'b0010, 8'h08, 4'b0000, 2'd1, 2'd2);
    add(2, 1, 4'b0000, 4'b0000, 8'h08, 4'b0000, 2'd1, 2'd2);
    add(2, 1, 4'b0000, 4'b0000, 8'h00, 4'b0000, 2'd1, 2'd0);
    // Approach 2: gap counter clears on demand, then gaps out
    add(1, 1, 4'b0100, 4'b0000, 8'h10, 4'b0100, 2'd2, 2'd1);
    add(2, 1, 4'b0000, 4'b0000, 8'h10, 4'b0100, 2'd2, 2'd1);
    add(1, 1, 4'b0100, 4'b0000, 8'h10, 4'b0100, 2'd2, 2'd1);
    add(4, 1, 4'b0001, 4'b0001, 8'h10, 4'b0100, 2'd2, 2'd1);
    add(1, 1, 4'b0001, 4'b0000, 8'h20, 4'b0000, 2'd2, 2'd2);
    add(1, 1, 4'b0001, 4'b0100, 8'h20, 4'b0000, 2'd2, 2'd2);
    // Reset during yellow aborts; first grant goes to lowest demanded approach
    add(1, 0, 4'b1100, 4'b0000, 8'h00, 4'b0000, 2'd3, 2'd0);
    add(2, 1, 4'b1100, 4'b0000, 8'h00, 4'b0000, 2'd3, 2'd0);
    add(1, 1, 4'b1100, 4'b0000, 8'h10, 4'b0100, 2'd2, 2'd1);
    // Expiry and gap-out together: a single yellow of normal length
    add(4, 1, 4'b1000, 4'b0000, 8'h10, 4'b0100, 2'd2, 2'd1);
    add(1, 1, 4'b1000, 4'b0100, 8'h20, 4'b0000, 2'd2, 2'd2);
    add(2, 1, 4'b1000, 4'b0000, 8'h20, 4'b0000, 2'd2, 2'd2);
    add(2, 1, 4'b1000, 4'b0000, 8'h00, 4'b0000, 2'd2, 2'd0);
    add(1, 1, 4'b1000, 4'b0000, 8'h40, 4'b1000, 2'd3, 2'd1);

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i]);
      drive(vecs[i].rst, vecs[i].sen, vecs[i].tex);
      compare(i);
    end

    // Hand sequence: end green 3, wait for approach 0, then reset mid-green
    drive(1'b1, 4'b0001, 4'b1000);
    n_vec++;
    if (lights !== 8'h80 || timer_en !== 4'h0) begin
      n_err++;
      $display("FAIL hand_yellow3 got lights=%h en=%b required lights=80 en=0000", lights, timer_en);
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      drive(1'b1, 4'b0001, 4'b0000);
      check_invariants(1000 + c);
      if (timer_en == 4'b0001) got = 1'b1;
    end
    n_vec++;
    if (!got || lights !== 8'h01 || phase !== 2'd0) begin
      n_err++;
      $display("FAIL hand_grant0 got lights=%h en=%b ph=%0d required lights=01 en=0001 ph=0 within 20 cycles",
               lights, timer_en, phase);
    end
    drive(1'b0, 4'b0001, 4'b0000);
    n_vec++;
    if (lights !== 8'h00 || timer_en !== 4'h0 || phase !== 2'd3 || state_o !== 2'b00) begin
      n_err++;
      $display("FAIL hand_reset_green got lights=%h en=%b ph=%0d st=%b required lights=00 en=0000 ph=3 st=00",
               lights, timer_en, phase, state_o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
